// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a 2^FIFO_DEPTH_LOG2-word FIFO; frames go out back to back while data is queued.
// Define UART_TX_PARITY_EN to compile in the parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_fifo #(
  parameter int CLK_TICKS_PER_BIT = 9,
  parameter int CLK_TICKS_WIDTH   = 4,
  parameter int DATA_BITS         = 8,
  parameter int STOP_BITS         = 1,
  parameter int FIFO_DEPTH_LOG2   = 4,
  parameter int PARITY_ODD        = 0
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [DATA_BITS-1:0]     data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  output logic                     tx_line,
  output logic                     tx_running,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     overflow,
  output logic [7:0]               frames_sent
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL = (FIFO_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [CLK_TICKS_WIDTH-1:0] TICK_MAX = CLK_TICKS_WIDTH'(CLK_TICKS_PER_BIT - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || CLK_TICKS_PER_BIT < 1 ||
      (CLK_TICKS_PER_BIT - 1) >= (1 << CLK_TICKS_WIDTH)) begin : g_bad_cfg
    $error("uart_tx_fifo: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0]       mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0]       head;
  logic                       push, pop, fifo_empty;

  assign data_ready = (fifo_count != FULL);
  assign fifo_empty = (fifo_count == '0);
  assign push       = data_valid && data_ready;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
      if (data_valid && !data_ready) overflow <= 1'b1;
    end
  end

  // ---------------- transmitter FSM ----------------
  state_t                     state, state_nxt;
  logic [CLK_TICKS_WIDTH-1:0] cnt, cnt_nxt;
  logic [3:0]                 bit_idx, bit_nxt;
  logic [DATA_BITS-1:0]       shreg, shreg_nxt;
  logic                       tx_nxt, bit_end, frame_done;
`ifdef UART_TX_PARITY_EN
  logic                       par, par_nxt;
`endif

  assign tx_running = (state != IDLE);
  assign bit_end    = (cnt == TICK_MAX);

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      tx_line     <= 1'b1;
      frames_sent <= '0;
`ifdef UART_TX_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
      tx_line <= tx_nxt;
      if (frame_done) frames_sent <= frames_sent + 8'd1;
`ifdef UART_TX_PARITY_EN
      par     <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bit_nxt    = bit_idx;
    shreg_nxt  = shreg;
    tx_nxt     = tx_line;
    pop        = 1'b0;
    frame_done = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt    = par;
`endif
    if (state != IDLE) cnt_nxt = bit_end ? '0 : cnt + 1'b1;

    case (state)
      IDLE:  pop = !fifo_empty;
      START: if (bit_end) begin
        state_nxt = DATA;
        tx_nxt    = shreg[0];
        shreg_nxt = shreg >> 1;
        bit_nxt   = '0;
      end
      DATA: if (bit_end) begin
        if (bit_idx == LAST_DATA) begin
          bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
          tx_nxt    = par;
`else
          state_nxt = STOP;
          tx_nxt    = 1'b1;
`endif
        end else begin
          bit_nxt   = bit_idx + 4'd1;
          tx_nxt    = shreg[0];
          shreg_nxt = shreg >> 1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_nxt = STOP;
        tx_nxt    = 1'b1;
        bit_nxt   = '0;
      end
`endif
      STOP: if (bit_end) begin
        if (bit_idx == LAST_STOP) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
          pop        = !fifo_empty;
        end else begin
          bit_nxt = bit_idx + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Loading the next word overrides the per-state update, so STOP chains straight into START.
    if (pop) begin
      state_nxt = START;
      cnt_nxt   = '0;
      shreg_nxt = head;
      tx_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_nxt   = (^head) ^ (PARITY_ODD != 0);
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: scoreboard of queued words checked cycle-by-cycle against tx_line,
// plus a 7-data-bit / 2-stop-bit instance.
module tb_uart_tx_fifo;
  localparam int T = 9;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL  = (1 + 8 + P + 1) * T;
  localparam int FL7 = (1 + 7 + P + 2) * T;

  logic       tb_clk_baudrate = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready, tx_line, tx_running, overflow;
  logic [4:0] fifo_count;
  logic [7:0] frames_sent;

  logic [6:0] data_in7 = '0;
  logic       data_valid7 = 1'b0;
  logic       data_ready7, tx_line7, tx_running7, overflow7;
  logic [4:0] fifo_count7;
  logic [7:0] frames_sent7;

  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];

  always #5 tb_clk_baudrate = ~tb_clk_baudrate;

  uart_tx_fifo dut (
    .clk_in(tb_clk_baudrate), .reset(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx_line(tx_line), .tx_running(tx_running),
    .fifo_count(fifo_count), .overflow(overflow), .frames_sent(frames_sent)
  );

  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) dut7 (
    .clk_in(tb_clk_baudrate), .reset(rst_n), .data_in(data_in7), .data_valid(data_valid7),
    .data_ready(data_ready7), .tx_line(tx_line7), .tx_running(tx_running7),
    .fifo_count(fifo_count7), .overflow(overflow7), .frames_sent(frames_sent7)
  );

  function automatic logic exp_bit(input logic [7:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  // Frame monitor: a falling tx_line pops the oldest expected word; every cycle of the frame is compared.
  logic [7:0] mon_w;
  bit         mon_ok, mon_abort, mon_spam = 1'b0;
  always begin
    @(negedge tb_clk_baudrate);
    if (rst_n === 1'b1 && tx_line === 1'b0) begin
      if (sb.size() == 0) begin
        if (!mon_spam) begin
          total++; bad++; mon_spam = 1'b1;
          $display("FAIL unexpected_frame: frame started with no word queued");
        end
      end else begin
        mon_w = sb.pop_front(); mon_ok = 1'b1; mon_abort = 1'b0;
        for (int i = 0; i < FL; i++) begin
          if (i > 0) @(negedge tb_clk_baudrate);
          if (rst_n !== 1'b1) begin mon_abort = 1'b1; break; end
          if (mon_ok && (tx_line !== exp_bit(mon_w, i / T) || tx_running !== 1'b1)) begin
            mon_ok = 1'b0;
            $display("FAIL frame_%02h: cycle %0d tx_line=%b running=%b, want tx_line=%b running=1",
                     mon_w, i, tx_line, tx_running, exp_bit(mon_w, i / T));
          end
        end
        if (!mon_abort) begin total++; if (!mon_ok) bad++; end
      end
    end
  end

  task automatic wr(input logic [7:0] d, input bit acc);
    data_in = d; data_valid = 1'b1;
    if (acc) sb.push_back(d);
    @(posedge tb_clk_baudrate); #1;
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge tb_clk_baudrate);
    #1;
    total++; if (tx_line !== 1'b1) begin bad++; $display("FAIL rst_tx_line: got %b want 1", tx_line); end
    total++; if (tx_running !== 1'b0) begin bad++; $display("FAIL rst_running: got %b want 0", tx_running); end
    total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", data_ready); end
    total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    total++; if (frames_sent !== 8'd0) begin bad++; $display("FAIL rst_frames: got %0d want 0", frames_sent); end
    total++; if (tx_line7 !== 1'b1 || tx_running7 !== 1'b0) begin
      bad++; $display("FAIL rst_dut7: tx=%b running=%b want 1/0", tx_line7, tx_running7);
    end
    rst_n = 1'b1;
    @(posedge tb_clk_baudrate); #1;
  endtask

  task automatic test_single();
    int run;
    wr(8'h65, 1'b1);
    total++; if (fifo_count !== 5'd1 || tx_line !== 1'b1) begin
      bad++; $display("FAIL single_pre: count=%0d tx=%b want 1/1", fifo_count, tx_line);
    end
    @(posedge tb_clk_baudrate); #1;
    total++; if (tx_line !== 1'b0 || tx_running !== 1'b1 || fifo_count !== 5'd0) begin
      bad++; $display("FAIL single_start: tx=%b running=%b count=%0d want 0/1/0", tx_line, tx_running, fifo_count);
    end
    run = (tx_running === 1'b1) ? 1 : 0;
    while (tx_running === 1'b1 && run < 300) begin
      @(posedge tb_clk_baudrate); #1;
      if (tx_running === 1'b1) run++;
    end
    total++; if (run != FL) begin bad++; $display("FAIL single_len: running %0d cycles want %0d", run, FL); end
    total++; if (frames_sent !== 8'd1) begin bad++; $display("FAIL single_frames: got %0d want 1", frames_sent); end
  endtask

  task automatic test_back_to_back();
    int run, peak;
    peak = 0;
    wr(8'h11, 1'b1); if (int'(fifo_count) > peak) peak = int'(fifo_count);
    wr(8'h22, 1'b1); if (int'(fifo_count) > peak) peak = int'(fifo_count);
    wr(8'h33, 1'b1); if (int'(fifo_count) > peak) peak = int'(fifo_count);
    run = 2;
    while (tx_running === 1'b1 && run < 1000) begin
      @(posedge tb_clk_baudrate); #1;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (tx_running === 1'b1) run++;
    end
    total++; if (peak != 2) begin bad++; $display("FAIL b2b_peak: got %0d want 2", peak); end
    total++; if (run != 3 * FL) begin bad++; $display("FAIL b2b_len: running %0d cycles want %0d", run, 3 * FL); end
    total++; if (frames_sent !== 8'd4) begin bad++; $display("FAIL b2b_frames: got %0d want 4", frames_sent); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_sb: %0d words unsent want 0", sb.size()); end
  endtask

  task automatic test_overflow();
    int budget;
    for (int i = 0; i < 17; i++) wr(8'(8'h80 + i), 1'b1);
    total++; if (fifo_count !== 5'd16 || data_ready !== 1'b0) begin
      bad++; $display("FAIL full: count=%0d ready=%b want 16/0", fifo_count, data_ready);
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
    wr(8'hEE, 1'b0);
    total++; if (overflow !== 1'b1 || fifo_count !== 5'd16) begin
      bad++; $display("FAIL ovf_drop: overflow=%b count=%0d want 1/16", overflow, fifo_count);
    end
    budget = 0;
    while (!(tx_running === 1'b0 && fifo_count === 5'd0) && budget < 3000) begin
      @(posedge tb_clk_baudrate); #1; budget++;
    end
    total++; if (budget >= 3000) begin bad++; $display("FAIL ovf_drain: timeout count=%0d want 0", fifo_count); end
    total++; if (frames_sent !== 8'd21) begin bad++; $display("FAIL ovf_frames: got %0d want 21", frames_sent); end
    total++; if (overflow !== 1'b1 || sb.size() != 0) begin
      bad++; $display("FAIL ovf_sticky: overflow=%b unsent=%0d want 1/0", overflow, sb.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int budget;
    wr(8'hA5, 1'b1);
    wr(8'h3C, 1'b1);
    repeat (38) @(posedge tb_clk_baudrate);
    #1;
    total++; if (tx_line !== 1'b0) begin bad++; $display("FAIL midrst_pre: tx=%b want 0", tx_line); end
    rst_n = 1'b0;
    @(posedge tb_clk_baudrate); #1;
    total++; if (tx_line !== 1'b1 || tx_running !== 1'b0) begin
      bad++; $display("FAIL midrst_line: tx=%b running=%b want 1/0", tx_line, tx_running);
    end
    total++; if (fifo_count !== 5'd0 || frames_sent !== 8'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL midrst_state: count=%0d frames=%0d ovf=%b want 0/0/0", fifo_count, frames_sent, overflow);
    end
    sb.delete();
    rst_n = 1'b1;
    @(posedge tb_clk_baudrate); #1;
    wr(8'h5A, 1'b1);
    @(posedge tb_clk_baudrate); #1;
    budget = 0;
    while (tx_running === 1'b1 && budget < 300) begin
      @(posedge tb_clk_baudrate); #1; budget++;
    end
    total++; if (frames_sent !== 8'd1 || sb.size() != 0) begin
      bad++; $display("FAIL midrst_after: frames=%0d unsent=%0d want 1/0", frames_sent, sb.size());
    end
  endtask

  task automatic test_7bit_2stop();
    int run, err;
    logic e;
    data_in7 = 7'h7F; data_valid7 = 1'b1;
    @(posedge tb_clk_baudrate); #1;
    data_valid7 = 1'b0;
    @(posedge tb_clk_baudrate); #1;
    run = 0; err = 0;
    while (tx_running7 === 1'b1 && run < 300) begin
      e = (run < T) ? 1'b0 : 1'b1;
      if (tx_line7 !== e || frames_sent7 !== 8'd0) begin
        if (err == 0) $display("FAIL d7_bits: cycle %0d tx=%b frames=%0d want tx=%b frames=0", run, tx_line7, frames_sent7, e);
        err++;
      end
      run++;
      @(posedge tb_clk_baudrate); #1;
    end
    total++; if (err != 0) bad++;
    total++; if (run != FL7) begin bad++; $display("FAIL d7_len: running %0d cycles want %0d", run, FL7); end
    total++; if (frames_sent7 !== 8'd1 || tx_line7 !== 1'b1) begin
      bad++; $display("FAIL d7_done: frames=%0d tx=%b want 1/1", frames_sent7, tx_line7);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_7bit_2stop();
    repeat (5) @(posedge tb_clk_baudrate);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
